i2s_frame_packer: RTL and testbench

- Upstream feeder for the I2S serializer: accepts the USB receive byte stream and assembles little-endian stereo frames (left sample, then right sample) at the selected sample size.
- Buffers complete frames in a small first-word-fall-through FIFO.
- Presents frames to the serializer's sample_left/sample_right inputs with a valid/ready handshake.

---
 rtl/i2s_frame_packer.sv | 167 ++++++++++++++++
 tb/tb_i2s_frame_packer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_frame_packer.sv
// Packs the USB receive byte stream into little-endian stereo frames and buffers
// them in a first-word-fall-through FIFO that feeds the I2S serializer.
//
// state   | meaning
// LEFT_S  | collecting left-sample bytes (r_idx = byte index)
// RIGHT_S | collecting right-sample bytes; the last byte pushes the frame
module i2s_frame_packer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [3:0]        sample_size,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [31:0]       sample_left,
    output logic [31:0]       sample_right,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic [ADDR_W:0]   fifo_level,
    output logic              size_error
);

    typedef enum logic {LEFT_S, RIGHT_S} state_t;

    state_t              r_state, w_state_nxt;
    logic [1:0]          r_idx, w_idx_nxt;
    logic [3:0]          r_code, w_code_nxt;
    logic [31:0]         r_left, w_left_nxt;
    logic [31:0]         r_right, w_right_nxt;
    logic                r_size_error, w_size_error_nxt;

    logic [31:0]         r_mem_l [FIFO_DEPTH];
    logic [31:0]         r_mem_r [FIFO_DEPTH];
    logic [ADDR_W-1:0]   r_wptr, r_rptr;
    logic [ADDR_W:0]     r_level;

    logic                w_boundary, w_code_ok, w_full, w_accept, w_last;
    logic                w_push, w_pop;
    logic [3:0]          w_code;
    logic [1:0]          w_last_idx;
    logic [31:0]         w_old, w_sample_new;

    always_comb begin
        w_boundary = (r_state == LEFT_S) && (r_idx == 2'd0);
        // The incoming code only matters at a frame boundary; mid-frame the latched one rules.
        w_code     = w_boundary ? sample_size : r_code;
        w_code_ok  = 1'b1;
        w_last_idx = 2'd0;
        case (w_code)
            4'd0:       w_last_idx = 2'd0;
            4'd1, 4'd3: w_last_idx = 2'd1;
            4'd4:       w_last_idx = 2'd3;
            default:    w_code_ok  = 1'b0;
        endcase
        w_full     = (r_level == FIFO_DEPTH[ADDR_W:0]);
        byte_ready = !rst && !flush && !w_full && w_code_ok;
        w_accept   = byte_valid && byte_ready;
        w_last     = (r_idx == w_last_idx);

        w_old        = (r_state == LEFT_S) ? r_left : r_right;
        w_sample_new = (r_idx == 2'd0) ? 32'd0 : w_old;
        w_sample_new[{r_idx, 3'b000} +: 8] = byte_in;
        if (w_code == 4'd1 && r_idx == 2'd1)
            w_sample_new[15:12] = 4'd0;
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_code_nxt       = r_code;
        w_left_nxt       = r_left;
        w_right_nxt      = r_right;
        w_size_error_nxt = r_size_error;
        w_push           = 1'b0;

        if (w_boundary)
            w_size_error_nxt = !w_code_ok;

        if (flush) begin
            w_state_nxt = LEFT_S;
            w_idx_nxt   = 2'd0;
            w_left_nxt  = 32'd0;
            w_right_nxt = 32'd0;
        end else if (w_accept) begin
            if (w_boundary)
                w_code_nxt = sample_size;
            if (r_state == LEFT_S) begin
                w_left_nxt = w_sample_new;
                if (w_last) begin
                    w_state_nxt = RIGHT_S;
                    w_idx_nxt   = 2'd0;
                end else begin
                    w_idx_nxt = r_idx + 2'd1;
                end
            end else begin
                w_right_nxt = w_sample_new;
                if (w_last) begin
                    w_push      = 1'b1;
                    w_state_nxt = LEFT_S;
                    w_idx_nxt   = 2'd0;
                end else begin
                    w_idx_nxt = r_idx + 2'd1;
                end
            end
        end
    end

    assign w_pop = frame_valid && frame_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= LEFT_S;
            r_idx        <= 2'd0;
            r_code       <= 4'd0;
            r_left       <= 32'd0;
            r_right      <= 32'd0;
            r_size_error <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_code       <= w_code_nxt;
            r_left       <= w_left_nxt;
            r_right      <= w_right_nxt;
            r_size_error <= w_size_error_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: the outputs are gated by frame_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_l[r_wptr] <= r_left;
            r_mem_r[r_wptr] <= w_sample_new;
        end
    end

    assign frame_valid  = (r_level != '0);
    assign sample_left  = frame_valid ? r_mem_l[r_rptr] : 32'd0;
    assign sample_right = frame_valid ? r_mem_r[r_rptr] : 32'd0;
    assign fifo_level   = r_level;
    assign size_error   = r_size_error;

endmodule

// File: tb/tb_i2s_frame_packer.sv
// Bench for i2s_frame_packer: byte-list/frame-queue reference model checked
// every cycle, plus literal expectations from hand-worked frames.
module tb_i2s_frame_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [3:0]  sample_size;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [31:0] sample_left;
    logic [31:0] sample_right;
    logic        frame_valid;
    logic        frame_ready;
    logic [2:0]  fifo_level;
    logic        size_error;

    i2s_frame_packer #(.FIFO_DEPTH(4), .ADDR_W(2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .sample_size(sample_size),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .sample_left(sample_left), .sample_right(sample_right),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .fifo_level(fifo_level), .size_error(size_error)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // reference model: accepted bytes of the frame in progress, plus a frame queue
    logic [31:0] q_l[$];
    logic [31:0] q_r[$];
    logic [7:0]  m_buf [8];
    int          m_cnt;
    logic [3:0]  m_code;
    logic        m_serr;
    logic        last_acc;

    function automatic int bps(input logic [3:0] c);
        case (c)
            4'd0: return 1;
            4'd1: return 2;
            4'd3: return 2;
            4'd4: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] build(input int base, input logic [3:0] c);
        logic [31:0] v;
        v = 32'd0;
        for (int k = 0; k < bps(c); k++)
            v = v | (32'(m_buf[base + k]) << (8 * k));
        if (c == 4'd1)
            v = v & 32'h0000_0FFF;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        q_l.delete();
        q_r.delete();
        m_cnt  = 0;
        m_code = 4'd0;
        m_serr = 1'b0;
    endtask

    function automatic logic exp_ready();
        logic [3:0] c;
        c = (m_cnt == 0) ? sample_size : m_code;
        return !flush && (q_l.size() < 4) && (bps(c) != 0);
    endfunction

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        logic acc, pop, bnd;
        @(negedge clk);
        chk("byte_ready", 32'(byte_ready), 32'(exp_ready()));
        chk("frame_valid", 32'(frame_valid), 32'(q_l.size() != 0));
        chk("fifo_level", 32'(fifo_level), 32'(q_l.size()));
        chk("size_error", 32'(size_error), 32'(m_serr));
        chk("sample_left", sample_left, (q_l.size() != 0) ? q_l[0] : 32'd0);
        chk("sample_right", sample_right, (q_r.size() != 0) ? q_r[0] : 32'd0);
        acc = byte_valid && exp_ready();
        pop = (q_l.size() != 0) && frame_ready && !flush;
        bnd = (m_cnt == 0);
        @(posedge clk);
        if (bnd)
            m_serr = (bps(sample_size) == 0);
        if (flush) begin
            q_l.delete();
            q_r.delete();
            m_cnt = 0;
        end else begin
            if (pop) begin
                void'(q_l.pop_front());
                void'(q_r.pop_front());
            end
            if (acc) begin
                if (m_cnt == 0)
                    m_code = sample_size;
                m_buf[m_cnt] = byte_in;
                m_cnt++;
                if (m_cnt == 2 * bps(m_code)) begin
                    q_l.push_back(build(0, m_code));
                    q_r.push_back(build(bps(m_code), m_code));
                    m_cnt = 0;
                end
            end
        end
        last_acc = acc;
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        do begin
            cycle();
            n++;
        end while (!last_acc && n < 50);
        if (!last_acc)
            chk("send_timeout", 32'd0, 32'd1);
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int nbytes);
        for (int k = 0; k < nbytes; k++)
            send_byte(w[8*k +: 8]);
    endtask

    task automatic pop_one();
        frame_ready = 1'b1;
        cycle();
        frame_ready = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        chk("rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("rst_frame_valid", 32'(frame_valid), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_left", sample_left, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] lv;
        int r;
        rst = 1'b1; flush = 1'b0; sample_size = 4'd3; byte_in = 8'd0;
        byte_valid = 1'b0; frame_ready = 1'b0; last_acc = 1'b0;
        model_reset();
        #3;
        do_reset();
        chk("rst_size_error", 32'(size_error), 32'd0);
        cycle();

        // 16-bit frame
        send_byte(8'h34); send_byte(8'h12); send_byte(8'h78); send_byte(8'h56);
        chk("s16_valid", 32'(frame_valid), 32'd1);
        chk("s16_left", sample_left, 32'h0000_1234);
        chk("s16_right", sample_right, 32'h0000_5678);
        chk("s16_level", 32'(fifo_level), 32'd1);
        pop_one();

        // 12-bit frame, upper nibble dropped
        sample_size = 4'd1;
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h01); send_byte(8'hA0);
        chk("s12_left", sample_left, 32'h0000_0FFF);
        chk("s12_right", sample_right, 32'h0000_0001);
        pop_one();

        // 32-bit: fill, stall, pop, wrap
        sample_size = 4'd4;
        for (int f = 1; f <= 4; f++) begin
            lv = 32'h1111_1111 * f;
            send_word(lv, 4);
            send_word(~lv, 4);
        end
        cycle();
        chk("full_level", 32'(fifo_level), 32'd4);
        chk("full_ready", 32'(byte_ready), 32'd0);
        chk("full_head", sample_left, 32'h1111_1111);
        pop_one();
        chk("after_pop_ready", 32'(byte_ready), 32'd1);
        send_word(32'h5555_5555, 4);
        send_word(~32'h5555_5555, 4);
        for (int f = 2; f <= 5; f++) begin
            chk("wrap_left", sample_left, 32'h1111_1111 * f);
            chk("wrap_right", sample_right, ~(32'h1111_1111 * f));
            pop_one();
        end
        chk("drained_valid", 32'(frame_valid), 32'd0);

        // 8-bit streaming with the consumer always ready
        sample_size = 4'd0;
        frame_ready = 1'b1;
        for (int i = 0; i < 10; i++)
            send_byte(8'(8'h40 + i));
        chk("stream_level", 32'(fifo_level), 32'd1);
        chk("stream_left", sample_left, 32'h0000_0048);
        frame_ready = 1'b0;
        do_flush();

        // size changed mid-frame takes effect on the next frame
        sample_size = 4'd0;
        send_byte(8'hAB);
        sample_size = 4'd4;
        send_byte(8'hCD);
        chk("switch_left", sample_left, 32'h0000_00AB);
        chk("switch_right", sample_right, 32'h0000_00CD);
        for (int i = 1; i <= 8; i++)
            send_byte(8'(i));
        pop_one();
        chk("switch32_left", sample_left, 32'h0403_0201);
        chk("switch32_right", sample_right, 32'h0807_0605);
        do_flush();

        // invalid size code at a boundary
        sample_size = 4'd2;
        cycle();
        chk("serr_set", 32'(size_error), 32'd1);
        chk("serr_ready", 32'(byte_ready), 32'd0);
        byte_in = 8'h11; byte_valid = 1'b1;
        cycle(); cycle(); cycle();
        chk("serr_noacc", 32'(fifo_level), 32'd0);
        sample_size = 4'd3;
        cycle();
        chk("serr_clear", 32'(size_error), 32'd0);
        chk("serr_resume", 32'(byte_ready), 32'd1);
        byte_valid = 1'b0;
        do_flush();

        // flush mid-frame
        sample_size = 4'd3;
        send_byte(8'h34); send_byte(8'h12); send_byte(8'h78);
        byte_in = 8'h99; byte_valid = 1'b1; flush = 1'b1;
        cycle();
        flush = 1'b0; byte_valid = 1'b0;
        chk("flush_level", 32'(fifo_level), 32'd0);
        chk("flush_valid", 32'(frame_valid), 32'd0);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        chk("flush_left", sample_left, 32'h0000_BBAA);
        chk("flush_right", sample_right, 32'h0000_DDCC);

        // async reset mid-frame
        send_byte(8'h01); send_byte(8'h02);
        do_reset();
        cycle();
        send_byte(8'h10); send_byte(8'h20); send_byte(8'h30); send_byte(8'h40);
        chk("rst_left2", sample_left, 32'h0000_2010);
        chk("rst_right2", sample_right, 32'h0000_4030);
        chk("rst_level2", 32'(fifo_level), 32'd1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 39));
            if (i % 37 == 0 || r >= 38)
                sample_size = (r == 39) ? 4'd7 : ((r == 38) ? 4'd2 : 4'(bps(4'd0)));
            if (i % 37 == 0) begin
                case ($urandom_range(0, 3))
                    0: sample_size = 4'd0;
                    1: sample_size = 4'd1;
                    2: sample_size = 4'd3;
                    default: sample_size = 4'd4;
                endcase
            end else if (r < 3) begin
                sample_size = 4'($urandom_range(0, 15));
            end
            byte_in     = 8'($urandom);
            byte_valid  = ($urandom_range(0, 3) != 0);
            frame_ready = ($urandom_range(0, 2) == 0);
            flush       = ($urandom_range(0, 99) == 0);
            cycle();
        end
        flush = 1'b0; byte_valid = 1'b0; frame_ready = 1'b0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
